// File: rtl/axi_chan_framer.sv
// Tags AXI-stream beats with a channel index and regenerates tlast at the programmed frame length.
// Latency 1 cycle into an empty 2-entry skid buffer; input ready is the registered buffer-not-full flag.
// Optional err_cnt port with AXI_CHAN_FRAMER_ERR_CNT_EN.
module axi_chan_framer #(
    parameter int DATA_WIDTH  = 32,
    parameter int TUSER_WIDTH = 8,
    parameter int CHAN_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   async_reset_n,
    input  logic                   enable,
    input  logic [CHAN_WIDTH-1:0]  num_chans_m1,
    input  logic                   s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tlast,
    output logic                   s_axis_tready,
    output logic                   m_axis_tvalid,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic                   locked
`ifdef AXI_CHAN_FRAMER_ERR_CNT_EN
    ,
    output logic [15:0]            err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]  tdata;
        logic [TUSER_WIDTH-1:0] tuser;
        logic                   tlast;
    } beat_t;

    state_t                 state_q, state_d;
    logic [CHAN_WIDTH-1:0]  len_q;
    logic [CHAN_WIDTH-1:0]  chan_q, chan_d;
    logic [TUSER_WIDTH-1:0] tuser_c;
    beat_t                  head_q, tail_q, push_beat;
    logic [1:0]             cnt_q, cnt_d;
    logic                   rdy_q;
    logic                   accept, push, pop, start, tlast_c, misalign;

    generate
        if (TUSER_WIDTH > CHAN_WIDTH) begin : g_ext
            assign tuser_c = {{(TUSER_WIDTH-CHAN_WIDTH){1'b0}}, chan_q};
        end else if (TUSER_WIDTH == CHAN_WIDTH) begin : g_eq
            assign tuser_c = chan_q;
        end else begin : g_trunc
            assign tuser_c = chan_q[TUSER_WIDTH-1:0];
        end
    endgenerate

    assign s_axis_tready = (state_q == SYNC) || ((state_q == RUN) && rdy_q);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign push          = accept && (state_q == RUN);
    assign pop           = m_axis_tvalid && m_axis_tready;
    assign start         = (state_q == IDLE) && enable;
    assign tlast_c       = (chan_q == len_q);
    assign misalign      = push && (s_axis_tlast != tlast_c);
    assign push_beat     = '{tdata: s_axis_tdata, tuser: tuser_c, tlast: tlast_c};
    assign locked        = (state_q == RUN);

    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        case (state_q)
            IDLE: if (enable) state_d = SYNC;
            SYNC: begin
                // Losing enable outranks a frame-end seen in the same cycle.
                if (!enable) begin
                    state_d = IDLE;
                end else if (accept && s_axis_tlast) begin
                    state_d = RUN;
                    chan_d  = '0;
                end
            end
            RUN: begin
                if (push) begin
                    // Upstream tlast forces realignment even when the count disagrees.
                    chan_d = (tlast_c || s_axis_tlast) ? '0 : chan_q + 1'b1;
                    if (!enable && tlast_c) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            chan_q  <= '0;
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            if (start) len_q <= num_chans_m1;
        end
    end

    // head_q is the output register; tail_q only holds a beat while head_q is stalled.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
            rdy_q  <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            rdy_q <= (cnt_d != 2'd2);
            case ({push, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) head_q <= push_beat;
                    else               tail_q <= push_beat;
                end
                2'b01: head_q <= tail_q;
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        head_q <= push_beat;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tvalid = (cnt_q != 2'd0);
    assign m_axis_tdata  = head_q.tdata;
    assign m_axis_tuser  = head_q.tuser;
    assign m_axis_tlast  = head_q.tlast;

`ifdef AXI_CHAN_FRAMER_ERR_CNT_EN
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            err_cnt <= 16'd0;
        end else if (start) begin
            err_cnt <= 16'd0;
        end else if (misalign && (err_cnt != 16'hFFFF)) begin
            err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi_chan_framer.sv
// Scoreboard bench for axi_chan_framer: directed beats push expected outputs, a negedge monitor pops and compares.
module tb_axi_chan_framer;

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  u;
        logic        l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  num_chans_m1 = 8'd0;
    logic        s_vld = 1'b0;
    logic [31:0] s_dat = 32'd0;
    logic        s_last = 1'b0;
    logic        s_rdy;
    logic        m_vld;
    logic [31:0] m_dat;
    logic [7:0]  m_user;
    logic        m_last;
    logic        m_rdy = 1'b1;
    logic        locked;
`ifdef AXI_CHAN_FRAMER_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int   vectors = 0;
    int   fails = 0;
    int   occ = 0;
    bit   chk_full = 1'b0;
    exp_t exp_q[$];

    axi_chan_framer dut (
        .clk(clk), .async_reset_n(rst_n), .enable(enable), .num_chans_m1(num_chans_m1),
        .s_axis_tvalid(s_vld), .s_axis_tdata(s_dat), .s_axis_tlast(s_last), .s_axis_tready(s_rdy),
        .m_axis_tvalid(m_vld), .m_axis_tdata(m_dat), .m_axis_tuser(m_user), .m_axis_tlast(m_last),
        .m_axis_tready(m_rdy), .locked(locked)
`ifdef AXI_CHAN_FRAMER_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && m_vld && m_rdy) begin
            if (exp_q.size() == 0) begin
                vectors++;
                fails++;
                $display("FAIL unexpected_beat: got data %0h, expected no beat", m_dat);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_data", m_dat, e.d);
                check("out_tuser", 32'(m_user), 32'(e.u));
                check("out_tlast", 32'(m_last), 32'(e.l));
            end
        end
        if (chk_full && occ == 2) check("ready_while_full", 32'(s_rdy), 32'd0);
    end

    // Independent occupancy count of the output buffer from port handshakes.
    always @(posedge clk) begin
        if (!rst_n) occ = 0;
        else occ = occ + int'(s_vld && s_rdy && locked) - int'(m_vld && m_rdy);
    end

    task automatic send(input logic [31:0] d, input logic l, input bit exp_out,
                        input logic [7:0] eu, input logic el);
        bit done = 1'b0;
        s_vld = 1'b1; s_dat = d; s_last = l;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (s_rdy) begin
                if (exp_out) exp_q.push_back('{d: d, u: eu, l: el});
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        s_vld = 1'b0;
        if (!done) begin
            vectors++;
            fails++;
            $display("FAIL send_timeout: data %0h not accepted, expected accept within 200 cycles", d);
        end
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0) done = 1'b1;
        end
        @(posedge clk); #1;
        if (!done) begin
            vectors++;
            fails++;
            $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
        end
    endtask

    initial begin
        #12;
        check("rst_s_ready", 32'(s_rdy), 32'd0);
        check("rst_m_valid", 32'(m_vld), 32'd0);
        check("rst_m_data", m_dat, 32'd0);
        check("rst_m_tuser", 32'(m_user), 32'd0);
        check("rst_m_tlast", 32'(m_last), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Sync then first aligned frames, 1-cycle latency.
        num_chans_m1 = 8'd3;
        enable = 1'b1;
        send(32'hA0, 1'b0, 1'b0, 8'd0, 1'b0);
        send(32'hA1, 1'b0, 1'b0, 8'd0, 1'b0);
        check("locked_before_tlast", 32'(locked), 32'd0);
        send(32'hA2, 1'b1, 1'b0, 8'd0, 1'b0);
        check("locked_after_sync", 32'(locked), 32'd1);
        send(32'hD0, 1'b0, 1'b1, 8'd0, 1'b0);
        check("latency_1", 32'(m_vld), 32'd1);
        for (int i = 1; i < 8; i++)
            send(32'hD0 + 32'(i), (i % 4) == 3, 1'b1, 8'(i % 4), (i % 4) == 3);
        wait_drain();

        // Backpressure: ready toggling every cycle.
        chk_full = 1'b1;
        fork
            for (int c = 0; c < 60; c++) begin
                @(posedge clk); #1;
                m_rdy = ~m_rdy;
            end
            for (int i = 0; i < 16; i++)
                send(32'h100 + 32'(i), (i % 4) == 3, 1'b1, 8'(i % 4), (i % 4) == 3);
        join
        m_rdy = 1'b1;
        wait_drain();
        chk_full = 1'b0;

        // Early upstream tlast realigns the count.
        send(32'hB0, 1'b0, 1'b1, 8'd0, 1'b0);
        send(32'hB1, 1'b1, 1'b1, 8'd1, 1'b0);
        send(32'hB2, 1'b0, 1'b1, 8'd0, 1'b0);
        send(32'hB3, 1'b0, 1'b1, 8'd1, 1'b0);
        send(32'hB4, 1'b0, 1'b1, 8'd2, 1'b0);
        send(32'hB5, 1'b1, 1'b1, 8'd3, 1'b1);
        wait_drain();
`ifdef AXI_CHAN_FRAMER_ERR_CNT_EN
        check("err_cnt_one", 32'(err_cnt), 32'd1);
`endif

        // Stop mid-frame: finish the frame, then IDLE.
        send(32'hC0, 1'b0, 1'b1, 8'd0, 1'b0);
        send(32'hC1, 1'b0, 1'b1, 8'd1, 1'b0);
        enable = 1'b0;
        send(32'hC2, 1'b0, 1'b1, 8'd2, 1'b0);
        check("locked_during_stop", 32'(locked), 32'd1);
        send(32'hC3, 1'b1, 1'b1, 8'd3, 1'b1);
        check("stop_locked", 32'(locked), 32'd0);
        check("stop_s_ready", 32'(s_rdy), 32'd0);
        wait_drain();
        check("idle_s_ready", 32'(s_rdy), 32'd0);

        // Single-channel frames.
        num_chans_m1 = 8'd0;
        enable = 1'b1;
        send(32'hE0, 1'b1, 1'b0, 8'd0, 1'b0);
`ifdef AXI_CHAN_FRAMER_ERR_CNT_EN
        check("err_cnt_cleared", 32'(err_cnt), 32'd0);
`endif
        for (int i = 1; i < 5; i++)
            send(32'hE0 + 32'(i), 1'b1, 1'b1, 8'd0, 1'b1);
        wait_drain();

        // Async reset with a beat held at the output.
        m_rdy = 1'b0;
        send(32'hF0, 1'b1, 1'b0, 8'd0, 1'b1);
        check("held_m_valid", 32'(m_vld), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_m_valid", 32'(m_vld), 32'd0);
        check("async_locked", 32'(locked), 32'd0);
        check("async_s_ready", 32'(s_rdy), 32'd0);
        check("async_m_data", m_dat, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
